// File: rtl/fp16_pkg.sv
// fp16_pkg: shared widths, constants and enums for the half-precision
// sequential divider.
package fp16_pkg;

    localparam int EXP_W  = 5;            // exponent field width
    localparam int FRAC_W = 10;           // fraction field width
    localparam int MANT_W = FRAC_W + 1;   // mantissa including hidden bit
    localparam int BIAS   = 15;
    localparam int E_W    = 7;            // signed working exponent width
    localparam int Q_W    = 12;           // quotient bits, Q[11] = integer bit

    localparam logic signed [E_W-1:0] BIAS_E = E_W'(BIAS);

    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] INF  = 16'h7C00;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        DIV,
        PACK,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

endpackage

// File: rtl/fp16_unpack.sv
// fp16_unpack: splits one IEEE-754 half into sign, effective exponent,
// mantissa with hidden bit, and operand class.
//   op   : raw half-precision operand
//   sign : sign bit
//   exp  : effective biased exponent (denormals report 1), zero-extended
//   mant : {hidden, fraction}
//   cls  : fp_class_e encoding (zero/denorm/normal/inf/nan)
module fp16_unpack
    import fp16_pkg::*;
(
    input  logic [15:0]       op,
    output logic              sign,
    output logic [E_W-1:0]    exp,
    output logic [MANT_W-1:0] mant,
    output logic [2:0]        cls
);

    logic [EXP_W-1:0]  efield;
    logic [FRAC_W-1:0] ffield;

    assign efield = op[FRAC_W+EXP_W-1:FRAC_W];
    assign ffield = op[FRAC_W-1:0];
    assign sign   = op[15];

    always_comb begin
        exp  = {2'b00, efield};
        mant = {1'b1, ffield};
        cls  = CLS_NORMAL;
        if (efield == '0) begin
            exp  = E_W'(1);
            mant = {1'b0, ffield};
            cls  = (ffield == '0) ? CLS_ZERO : CLS_DENORM;
        end else if (efield == {EXP_W{1'b1}}) begin
            cls  = (ffield == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/fp16_div_seq.sv
// fp16_div_seq: sequential half-precision divider (truncating).
// Flow: IDLE -> NORM (normalise denormal mantissas) -> DIV (12-cycle
// restoring division) -> PACK (exponent adjust, overflow/underflow,
// register result) -> DONE (done pulse). Special operands go IDLE -> PACK.
//   clk_i, rst_i      : clock, async active-high reset
//   start_i           : request, sampled only in IDLE with opA_i/opB_i
//   busy_o            : operation in flight
//   done_o            : one-cycle result-valid pulse
//   DIV_o             : quotient, held until the next done_o
//   ovf_o/udf_o/dbz_o : overflow / flush-to-zero / divide-by-zero, held
module fp16_div_seq
    import fp16_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] opA_i,
    input  logic [15:0] opB_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] DIV_o,
    output logic        ovf_o,
    output logic        udf_o,
    output logic        dbz_o
);

    state_e state_q, state_d;

    logic              a_sign, b_sign;
    logic [E_W-1:0]    a_exp, b_exp;
    logic [MANT_W-1:0] a_mant, b_mant;
    logic [2:0]        a_cls, b_cls;

    fp16_unpack u_unpack_a (.op(opA_i), .sign(a_sign), .exp(a_exp), .mant(a_mant), .cls(a_cls));
    fp16_unpack u_unpack_b (.op(opB_i), .sign(b_sign), .exp(b_exp), .mant(b_mant), .cls(b_cls));

    // Special-operand result, decided from the live inputs at acceptance.
    logic        special, spec_dbz, sgn;
    logic [15:0] spec_res;

    always_comb begin
        sgn      = a_sign ^ b_sign;
        special  = 1'b1;
        spec_dbz = 1'b0;
        spec_res = {sgn, 15'b0};
        if (a_cls == CLS_NAN || b_cls == CLS_NAN ||
            (a_cls == CLS_ZERO && b_cls == CLS_ZERO) ||
            (a_cls == CLS_INF && b_cls == CLS_INF)) begin
            spec_res = QNAN;
        end else if (a_cls == CLS_INF) begin
            spec_res = {sgn, 15'b0} | INF;
        end else if (b_cls == CLS_INF) begin
            spec_res = {sgn, 15'b0};
        end else if (b_cls == CLS_ZERO) begin
            spec_res = {sgn, 15'b0} | INF;
            spec_dbz = 1'b1;
        end else if (a_cls == CLS_ZERO) begin
            spec_res = {sgn, 15'b0};
        end else begin
            special  = 1'b0;
        end
    end

    logic                    sign_q, is_spec_q, spec_dbz_q;
    logic [15:0]             spec_res_q;
    logic signed [E_W-1:0]   ea_q, eb_q;
    logic [MANT_W-1:0]       ma_q, mb_q;
    logic [Q_W-1:0]          rem_q, quo_q;
    logic [3:0]              cnt_q;
    logic [15:0]             div_q;
    logic                    ovf_q, udf_q, dbz_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = special ? PACK : NORM;
            NORM: if (ma_q[MANT_W-1] && mb_q[MANT_W-1]) state_d = DIV;
            DIV:  if (cnt_q == 4'(Q_W - 1)) state_d = PACK;
            PACK: state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pack: quotient lies in (0.5, 2), so at most one normalising shift.
    logic signed [E_W-1:0] e_raw, e_adj;
    logic [E_W-1:0]        sh;
    logic [MANT_W-1:0]     m;
    logic [FRAC_W-1:0]     den;
    logic [15:0]           pk_res;
    logic                  pk_ovf, pk_udf, pk_dbz;

    always_comb begin
        e_raw  = ea_q - eb_q + BIAS_E;
        e_adj  = quo_q[Q_W-1] ? e_raw : e_raw - E_W'(1);
        m      = quo_q[Q_W-1] ? quo_q[Q_W-1:1] : quo_q[Q_W-2:0];
        sh     = E_W'(1) - e_adj;
        den    = FRAC_W'(m >> sh);
        pk_ovf = 1'b0;
        pk_udf = 1'b0;
        pk_dbz = 1'b0;
        pk_res = {sign_q, e_adj[EXP_W-1:0], m[FRAC_W-1:0]};
        if (is_spec_q) begin
            pk_res = spec_res_q;
            pk_dbz = spec_dbz_q;
        end else if (e_adj >= E_W'(31)) begin
            pk_res = {sign_q, 15'b0} | INF;
            pk_ovf = 1'b1;
        end else if (e_adj <= E_W'(0)) begin
            // Denormal: field is zero, fraction is mantissa >> (1 - E).
            pk_res = {sign_q, 5'b0, den};
            pk_udf = (den == '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sign_q     <= 1'b0;
            is_spec_q  <= 1'b0;
            spec_dbz_q <= 1'b0;
            spec_res_q <= '0;
            ea_q       <= '0;
            eb_q       <= '0;
            ma_q       <= '0;
            mb_q       <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            div_q      <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    sign_q     <= sgn;
                    is_spec_q  <= special;
                    spec_dbz_q <= spec_dbz;
                    spec_res_q <= spec_res;
                    ea_q       <= a_exp;
                    eb_q       <= b_exp;
                    ma_q       <= a_mant;
                    mb_q       <= b_mant;
                end
                NORM: begin
                    if (!ma_q[MANT_W-1]) begin
                        ma_q <= ma_q << 1;
                        ea_q <= ea_q - E_W'(1);
                    end
                    if (!mb_q[MANT_W-1]) begin
                        mb_q <= mb_q << 1;
                        eb_q <= eb_q - E_W'(1);
                    end
                    rem_q <= {1'b0, ma_q};
                    quo_q <= '0;
                    cnt_q <= '0;
                end
                DIV: begin
                    // Restoring step; remainder stays below 2*divisor.
                    if (rem_q >= {1'b0, mb_q}) begin
                        rem_q <= (rem_q - {1'b0, mb_q}) << 1;
                        quo_q <= {quo_q[Q_W-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_q << 1;
                        quo_q <= {quo_q[Q_W-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 4'd1;
                end
                PACK: begin
                    div_q <= pk_res;
                    ovf_q <= pk_ovf;
                    udf_q <= pk_udf;
                    dbz_q <= pk_dbz;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign DIV_o  = div_q;
    assign ovf_o  = ovf_q;
    assign udf_o  = udf_q;
    assign dbz_o  = dbz_q;

endmodule

// File: doc/fp16_div_seq.md
FP16_DIV_SEQ -- requirements
Module: fp16_div_seq

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port start_i, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port opA_i, input, 16 bits: dividend, IEEE-754 half (1 sign, 5 exponent, 10 fraction); sampled with start_i.
REQ-005 SHALL have port opB_i, input, 16 bits: divisor, same format; sampled with start_i.
REQ-006 SHALL have port busy_o, output, 1 bit: high from the cycle after start acceptance until done_o.
REQ-007 SHALL have port done_o, output, 1 bit: one-cycle pulse, DIV_o valid.
REQ-008 SHALL have port DIV_o, output, 16 bits: quotient opA_i/opB_i, held until the next done_o.
REQ-009 SHALL have port ovf_o, output, 1 bit: result overflowed to Inf; valid with done_o, held.
REQ-010 SHALL have port udf_o, output, 1 bit: nonzero exact result flushed to zero; valid with done_o, held.
REQ-011 SHALL have port dbz_o, output, 1 bit: finite nonzero divided by zero; valid with done_o, held.

Function
REQ-012 SHALL implement FSM states IDLE, NORM, DIV, PACK, DONE; IDLE->NORM on start_i; DONE->IDLE unconditionally.
REQ-013 SHALL ignore start_i while not in IDLE; operands latched internally at acceptance.
REQ-014 SHALL treat exponent 0 as denormal (hidden bit 0, effective exponent 1), exponent 31 with fraction 0 as Inf, and exponent 31 with nonzero fraction as NaN.
REQ-015 NORM SHALL shift both mantissas left by one bit per cycle, in parallel, and decrement the per-operand exponent until hidden bits are set; duration 1 + max leading-zero count (1 cycle if both normal).
REQ-016 DIV SHALL run radix-2 restoring division, one quotient bit per cycle, 12 cycles, giving Q[11:0] with Q[11] the integer bit.
REQ-017 Exponent SHALL be computed as E = expA - expB + 15 in signed 7-bit; if Q[11]=0, Q<<=1 and E-=1.
REQ-018 Rounding SHALL be truncation toward zero; sign = signA XOR signB.
REQ-019 If E>=31, the result SHALL be sign|0x7C00 and ovf_o SHALL be 1.
REQ-020 If E<=0, the mantissa SHALL be shifted right by 1-E to produce a denormal; a zero field from a nonzero quotient SHALL give signed zero and udf_o=1.
REQ-021 Specials SHALL skip NORM/DIV and go IDLE->PACK: NaN in, 0/0, or Inf/Inf -> 0x7E00; x/0 (x finite nonzero) -> signed Inf with dbz_o=1; 0/x -> signed 0; Inf/x -> signed Inf; x/Inf -> signed 0.
REQ-022 Latency: normal operands SHALL give done_o exactly 15 cycles after the start-accept edge (1 NORM + 12 DIV + PACK + DONE); specials 2 cycles.
REQ-023 PACK SHALL register DIV_o and the flags; done_o SHALL be high in DONE only.

Reset
REQ-024 rst_i SHALL immediately force IDLE, busy_o=0, done_o=0, DIV_o=0x0000, ovf_o=udf_o=dbz_o=0.
REQ-025 Reset mid-operation SHALL abort without any later done_o; start_i SHALL be accepted on the first clock after rst_i deasserts.

Structure
REQ-026 Package fp16_pkg SHALL hold widths (EXP_W=5, FRAC_W=10), BIAS=15, constants QNAN=0x7E00 and INF=0x7C00, and the FSM state enum.
REQ-027 Sub-module fp16_unpack SHALL be instantiated per operand, outputting sign, exponent, mantissa with hidden bit, and class (zero/denorm/normal/inf/nan).

Verification
REQ-028 0x4600/0x4000 (6/2) -> DIV_o=0x4200, flags 0, done_o 15 cycles after start.
REQ-029 0x3C00/0x4200 (1/3) -> DIV_o=0x3555 (truncated), flags 0.
REQ-030 0x7BFF/0x0001 -> DIV_o=0x7C00, ovf_o=1, NORM lasting 11 cycles; 0x0001/0x4400 -> 0x0000, udf_o=1; 0x0400/0x4400 -> 0x0100, udf_o=0.
REQ-031 0x3C00/0x0000 -> 0x7C00, dbz_o=1, done_o at +2; 0x0000/0x0000 -> 0x7E00, dbz_o=0; 0xC000/0x4000 -> 0xBC00.
REQ-032 rst_i pulsed in DIV -> busy_o=0 immediately, no done_o within 20 cycles; the next start produces the correct result.
REQ-033 start_i held high through an operation with changing operands -> only the first operands are used; one done_o per accepted start.
